// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU definitions: datapath width and the one-hot opcode constants
// that the ALU, the decoder and the mul/div sequencer all agree on.
package alu_muldiv_seq_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ALUOP_W    = 16;

    localparam logic [ALUOP_W-1:0] ALUOP_NONE = 16'h0000;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 16'h0001;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 16'h0002;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 16'h0004;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 16'h0008;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative MULTU/DIVU sequencer. Borrows the shared EX-stage ALU for 32 cycles
// per operation and returns {hi,lo} to the HI/LO file over a valid/ready pair.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_div,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  cancel,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_hi,
    output logic [DATA_WIDTH-1:0] resp_lo,
    output logic                  alu_own,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [ALUOP_W-1:0]    alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_carryout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t                  state, state_nx;
    logic [4:0]              cnt;
    logic [DATA_WIDTH-1:0]   hi, lo, opb;
    logic                    is_div;
    logic [DATA_WIDTH-1:0]   div_s;
    logic                    qbit;
    logic [DATA_WIDTH-1:0]   step_hi, step_lo;
    logic                    accept;

    assign accept = (state == S_IDLE) && req_valid && !cancel;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_RUN;
            S_RUN: begin
                if (cancel)            state_nx = S_IDLE;
                else if (cnt == 5'd31) state_nx = S_DONE;
            end
            S_DONE: if (cancel || resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand mux and one shift-add / shift-subtract step. Divide works on the
    // {r,q} pair shifted left; a set r msb means the 33-bit remainder exceeds any divisor.
    always_comb begin
        alu_A   = '0;
        alu_B   = '0;
        alu_op  = ALUOP_NONE;
        div_s   = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};
        qbit    = hi[DATA_WIDTH-1] | ~alu_carryout;
        step_hi = hi;
        step_lo = lo;
        if (state == S_RUN) begin
            if (is_div) begin
                alu_A   = div_s;
                alu_B   = opb;
                alu_op  = ALUOP_SUB;
                step_hi = qbit ? alu_result : div_s;
                step_lo = {lo[DATA_WIDTH-2:0], qbit};
            end else begin
                alu_A   = hi;
                alu_B   = lo[0] ? opb : '0;
                alu_op  = ALUOP_ADD;
                step_hi = {alu_carryout, alu_result[DATA_WIDTH-1:1]};
                step_lo = {alu_result[0], lo[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            is_div <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt    <= '0;
                is_div <= req_div;
                hi     <= '0;
                lo     <= req_div ? req_a : req_b;
                opb    <= req_div ? req_b : req_a;
            end else if (state == S_RUN && !cancel) begin
                cnt <= cnt + 5'd1;
                hi  <= step_hi;
                lo  <= step_lo;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign alu_own    = (state == S_RUN);
    assign resp_hi    = hi;
    assign resp_lo    = lo;

endmodule
